// File: rtl/svc_rv_bpred_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// The lookup has one cycle of registered latency and reads state as it was before any same-cycle update.
module svc_rv_bpred_btb #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int TAG_W = 8,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lu_en,
    input  logic [XLEN-1:0] lu_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_jump,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX_W = $clog2(DEPTH);

    // Counter constants derived from all-ones so that they stay legal for CNT_W=1.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_MAX ^ (CNT_MAX << 1);
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_MAX ^ (CNT_MAX >> 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_MAX >> 1;

    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [CNT_W-1:0] cnt_q    [DEPTH];

    logic [IDX_W-1:0] lu_idx;
    logic [TAG_W-1:0] lu_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             lu_hit;
    logic             upd_hit;
    logic             upd_alloc;
    logic [CNT_W-1:0] upd_cnt;
    logic             unused_pc_bits;

    assign lu_idx  = lu_pc[IDX_W+1:2];
    assign lu_tag  = lu_pc[TAG_W+IDX_W+1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[TAG_W+IDX_W+1:IDX_W+2];

    assign lu_hit    = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_alloc = !upd_hit && upd_taken;

    assign unused_pc_bits = ^{lu_pc, upd_pc};

    // NOTE: combinational blocks use blocking '=' with a default on the first line,
    // so no path leaves upd_cnt unassigned and no latch is inferred.
    always_comb begin
        upd_cnt = cnt_q[upd_idx];
        if (upd_jump) begin
            upd_cnt = CNT_MAX;
        end else if (upd_taken) begin
            if (upd_cnt != CNT_MAX) upd_cnt = upd_cnt + CNT_ONE;
        end else if (upd_cnt != '0) begin
            upd_cnt = upd_cnt - CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every read in this edge
    // sees pre-edge values; that is what gives lookups read-before-write ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_WNT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                cnt_q[upd_idx] <= upd_cnt;
            end else if (upd_alloc) begin
                valid_q[upd_idx] <= 1'b1;
                cnt_q[upd_idx]   <= upd_jump ? CNT_MAX : CNT_WT;
            end
        end
    end

    // NOTE: tags and targets are deliberately left out of reset; they are only
    // observed through a valid bit, and keeping them reset-free lets them map to RAM.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid) begin
            if (upd_alloc) tag_q[upd_idx] <= upd_tag;
            if (upd_alloc || (upd_hit && (upd_jump || upd_taken))) begin
                target_q[upd_idx] <= upd_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (lu_en) begin
            pred_hit    <= lu_hit;
            pred_taken  <= lu_hit && cnt_q[lu_idx][CNT_W-1];
            pred_target <= lu_hit ? target_q[lu_idx] : '0;
        end
    end

endmodule

// File: tb/tb_svc_rv_bpred_btb.sv
// Randomised scoreboard bench for svc_rv_bpred_btb against an entry-table reference model.
module tb_svc_rv_bpred_btb;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int TAG_W = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int CWT   = 1 << (CNT_W - 1);
    localparam int CWNT  = CWT - 1;

    logic            clk;
    logic            rst;
    logic            lu_en;
    logic [XLEN-1:0] lu_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_jump;
    logic [XLEN-1:0] upd_target;

    svc_rv_bpred_btb #(
        .XLEN (XLEN),
        .DEPTH(DEPTH),
        .TAG_W(TAG_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lu_en      (lu_en),
        .lu_pc      (lu_pc),
        .pred_hit   (pred_hit),
        .pred_taken (pred_taken),
        .pred_target(pred_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_jump   (upd_jump),
        .upd_target (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              hit;
        bit              taken;
        logic [XLEN-1:0] target;
        string           name;
    } exp_t;

    typedef struct {
        bit              valid;
        int unsigned     tag;
        logic [XLEN-1:0] target;
        int              cnt;
    } ent_t;

    exp_t            exp_q[$];
    ent_t            model[DEPTH];
    bit              out_hit;
    bit              out_taken;
    logic [XLEN-1:0] out_target;
    int              checks;
    int              failures;

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic int unsigned tag_of(input logic [XLEN-1:0] pc);
        return int'((pc / (4 * DEPTH)) % (1 << TAG_W));
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after the coming edge.
    task automatic step(input bit r, input bit le, input logic [XLEN-1:0] lpc,
                        input bit uv, input logic [XLEN-1:0] upc, input bit ut,
                        input bit uj, input logic [XLEN-1:0] utg, input string name);
        exp_t e;
        int   li;
        int   ui;
        bit   hit;
        @(negedge clk);
        rst        = r;
        lu_en      = le;
        lu_pc      = lpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_jump   = uj;
        upd_target = utg;
        if (r) begin
            out_hit    = 0;
            out_taken  = 0;
            out_target = '0;
            for (int i = 0; i < DEPTH; i++) begin
                model[i].valid = 0;
                model[i].cnt   = CWNT;
            end
        end else begin
            if (le) begin
                li         = idx_of(lpc);
                hit        = model[li].valid && (model[li].tag == tag_of(lpc));
                out_hit    = hit;
                out_taken  = hit && (model[li].cnt >= CWT);
                out_target = hit ? model[li].target : '0;
            end
            if (uv) begin
                ui  = idx_of(upc);
                hit = model[ui].valid && (model[ui].tag == tag_of(upc));
                if (hit) begin
                    if (uj) begin
                        model[ui].cnt    = CMAX;
                        model[ui].target = utg;
                    end else if (ut) begin
                        model[ui].cnt    = (model[ui].cnt < CMAX) ? model[ui].cnt + 1 : CMAX;
                        model[ui].target = utg;
                    end else begin
                        model[ui].cnt = (model[ui].cnt > 0) ? model[ui].cnt - 1 : 0;
                    end
                end else if (ut) begin
                    model[ui].valid  = 1;
                    model[ui].tag    = tag_of(upc);
                    model[ui].target = utg;
                    model[ui].cnt    = uj ? CMAX : CWT;
                end
            end
        end
        e.hit    = out_hit;
        e.taken  = out_taken;
        e.target = out_target;
        e.name   = name;
        exp_q.push_back(e);
    endtask

    task automatic lookup(input logic [XLEN-1:0] pc, input string name);
        step(0, 1, pc, 0, '0, 0, 0, '0, name);
    endtask

    task automatic update(input logic [XLEN-1:0] pc, input bit t, input bit j,
                          input logic [XLEN-1:0] tg, input string name);
        step(0, 0, '0, 1, pc, t, j, tg, name);
    endtask

    // Monitor: the DUT presents fresh registered outputs after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pred_hit !== e.hit || pred_taken !== e.taken || pred_target !== e.target) begin
                    failures++;
                    $display("FAIL %s: got hit=%0b taken=%0b target=%h, expected hit=%0b taken=%0b target=%h",
                             e.name, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.target);
                end
            end
        end
    end

    initial begin
        logic [XLEN-1:0] rpc;
        logic [XLEN-1:0] rlpc;
        bit              rt;
        checks     = 0;
        failures   = 0;
        rst        = 1;
        lu_en      = 0;
        lu_pc      = '0;
        upd_valid  = 0;
        upd_pc     = '0;
        upd_taken  = 0;
        upd_jump   = 0;
        upd_target = '0;

        step(1, 0, '0, 0, '0, 0, 0, '0, "reset0");
        step(1, 1, 32'h100, 1, 32'h100, 1, 0, 32'h80, "reset_ignores_upd");
        lookup(32'h100, "post_reset_miss");

        update(32'h100, 1, 0, 32'h80, "alloc_100");
        lookup(32'h100, "alloc_weak_taken");
        repeat (2) update(32'h100, 0, 0, 32'h0, "dec");
        lookup(32'h100, "cnt_00_hit_nt");
        repeat (3) update(32'h100, 0, 0, 32'h0, "dec_sat");
        lookup(32'h100, "cnt_sat_low");
        repeat (4) update(32'h100, 1, 0, 32'h84, "inc_sat");
        lookup(32'h100, "cnt_sat_high");

        update(32'h200, 1, 0, 32'h300, "alias_200");
        lookup(32'h100, "aliased_out");
        lookup(32'h200, "alias_hit");

        update(32'h104, 0, 0, 32'h500, "nt_miss");
        lookup(32'h104, "nt_miss_no_alloc");

        update(32'h40, 1, 1, 32'h400, "jal_alloc");
        lookup(32'h40, "jal_taken");
        update(32'h40, 0, 0, 32'h0, "jal_dec");
        lookup(32'h40, "jal_still_taken");

        lookup(32'h100, "hold_setup_miss");
        step(0, 0, 32'h200, 0, '0, 0, 0, '0, "hold_miss");
        lookup(32'h40, "hold_setup_hit");
        step(0, 0, 32'h200, 0, '0, 0, 0, '0, "hold_hit");

        update(32'h100, 1, 0, 32'h88, "relearn_100");
        step(0, 1, 32'h100, 1, 32'h100, 0, 0, '0, "rbw_old_dir");
        lookup(32'h100, "rbw_new_dir");

        step(1, 0, '0, 0, '0, 0, 0, '0, "mid_reset");
        lookup(32'h100, "reset_miss_100");
        lookup(32'h40, "reset_miss_40");
        lookup(32'h200, "reset_miss_200");

        for (int n = 0; n < 2000; n++) begin
            rpc  = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            rpc  = rpc | ($urandom_range(0, 1) << 20);
            rlpc = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) rlpc = rpc;
            rt = ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, rlpc,
                 $urandom_range(0, 1) == 1, rpc, rt, rt && ($urandom_range(0, 4) == 0),
                 $urandom & 32'hffff_fffc, "random");
        end
        step(0, 0, '0, 0, '0, 0, 0, '0, "final_idle");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
